pkt_gen_ctrl: RTL and testbench
===============================

// Module: pkt_gen_ctrl
// PURPOSE
//  Frame scheduler downstream of the SPI debug register file. It turns the
//  io_* config registers into a per-frame request/ack handshake towards the
//  Ethernet frame builder: frame count, frame length sequence and inter-frame
//  gap. It returns io_send_done and the 48-bit io_total_send_count_{h,m,l}.
// PARAMETERS
//  LEN_MIN   64    minimum frame length (bytes); lower init values are clamped
//  LEN_MAX   1518  maximum frame length (bytes); higher init values are clamped
//  IFG_MIN   12    minimum gap (clk cycles); smaller inter_frame_gap is raised
//  WDOG_CYC  4096  XMIT timeout in cycles (used only with the _WDOG_EN macro)
// PORTS
//  clk_i              in   1   clock; single clock domain
//  rstb_i             in   1   asynchronous reset, active low
//  enable_i           in   1   run request (io_enable_out)
//  suspend_i          in   1   pause at the next gap (io_suspend_out)
//  send_mode_i        in   1   0 = continuous, 1 = send send_count_i frames
//  send_count_i       in   32  {io_send_count_hign, io_send_count_low}
//  pkt_len_mode_i     in   1   0 = fixed length, 1 = incrementing length
//  pkt_len_init_i     in   16  first frame length (io_pkt_len_init_out)
//  ifg_i              in   16  inter-frame gap in cycles (io_inter_frame_gap_out)
//  total_clr_i        in   1   clear the total counter (io_total_send_count_clr_out)
//  frm_req_o          out  1   frame request to the builder
//  frm_len_o          out  16  length of the requested frame; stable while req=1
//  frm_ack_i          in   1   builder accepts the request
//  frm_done_i         in   1   single-cycle pulse: builder sent the last byte
//  send_done_o        out  1   count-mode run complete (io_send_done_in)
//  total_cnt_o        out  48  frames sent since reset/clear; {h,m,l} = [47:32],[31:16],[15:0]
//  busy_o             out  1   FSM is not in IDLE
//  err_o              out  1   sticky watchdog error; tied to 0 without the macro
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0; internal len, sent and gap counters 0.
//  - IDLE: if enable_i=1 && suspend_i=0, latch mode, count and clamped init
//    length into shadow registers and clear sent counter. Then:
//      mode=1 && count=0 -> DONE; otherwise -> REQ on the next cycle.
//    Config changes during a run take effect only at the next IDLE start.
//  - REQ: frm_req_o=1 and frm_len_o=len. When frm_ack_i=1 in a cycle where
//    req=1 -> XMIT and req=0 on the next cycle. The request is never withdrawn
//    before ack, including when enable drops.
//  - XMIT: wait for frm_done_i. On done: sent+=1 and total_cnt+=1 (wraps at
//    2^48). If pkt_len_mode=1, len+=1, and len==LEN_MAX reloads the clamped
//    init value. Next state:
//      mode=1 && sent+1==count -> DONE
//      enable_i=0               -> IDLE
//      otherwise                -> GAP, gap counter = max(ifg_i, IFG_MIN)
//  - GAP: the counter decrements each cycle. At 1:
//      enable_i=0  -> IDLE
//      suspend_i=1 -> hold at 1 until suspend clears (or enable drops)
//      otherwise   -> REQ
//    Frame-to-frame spacing from the done pulse to req is exactly gap+1 cycles.
//  - DONE: send_done_o=1, held until enable_i=0, then IDLE with send_done_o=0.
//  - total_clr_i is a synchronous clear. If it coincides with a done
//    increment, the clear wins (result 0). The clear does not affect the FSM.
//  - A frm_done_i or frm_ack_i outside XMIT/REQ is ignored.
//  - Async reset mid-frame returns everything to reset values immediately.
// CONFIGURATION
//  PKT_GEN_CTRL_WDOG_EN defined: a cycle counter runs in XMIT. If frm_done_i
//    is absent for WDOG_CYC cycles, err_o is set (sticky until rstb_i), the
//    FSM goes to IDLE, and no count increment occurs. A restart needs an
//    enable_i low->high.
//  PKT_GEN_CTRL_WDOG_EN undefined: no watchdog logic; err_o=0; XMIT waits
//    indefinitely.
// TESTING
//  1 mode=1, count=3, len=100 fixed, ifg=20, ack 1 cycle after req, done 50
//    cycles later -> 3 reqs with frm_len_o=100, req-to-req spacing after done
//    =21 cycles, send_done_o=1, total_cnt_o=3.
//  2 mode=1, pkt_len_mode=1, init=1516, count=4 -> frm_len_o sequence
//    1516,1517,1518,1516.
//  3 init=10, ifg=3 -> frm_len_o=64 and spacing after done=13 cycles
//    (clamped to LEN_MIN/IFG_MIN).
//  4 continuous mode, suspend_i=1 after frame 2 for 200 cycles -> no req
//    during the suspend; req 1 cycle after suspend=0; drop enable in REQ ->
//    req held until ack, frame completes, FSM returns to IDLE with busy_o=0.
//  5 total_clr_i pulsed in the same cycle as frm_done_i with total=0xFFFF_FFFF_FFFF
//    -> total=0; without the clear -> wraps to 0. mode=1, count=0 -> DONE, no req.
//  6 WDOG_EN, WDOG_CYC=16, withhold frm_done_i -> err_o=1 after 16 XMIT cycles,
//    FSM in IDLE, total unchanged; without the macro err_o stays 0.

Source files
------------

// File: rtl/pkt_gen_ctrl_if.sv
// Frame request/ack handshake between pkt_gen_ctrl (master) and the
// Ethernet frame builder (slave).
interface pkt_gen_ctrl_if;
    logic        frm_req;
    logic [15:0] frm_len;
    logic        frm_ack;
    logic        frm_done;

    modport master (
        output frm_req,
        output frm_len,
        input  frm_ack,
        input  frm_done
    );

    modport slave (
        input  frm_req,
        input  frm_len,
        output frm_ack,
        output frm_done
    );
endinterface

// File: rtl/pkt_gen_ctrl.sv
// pkt_gen_ctrl: frame scheduler between the SPI debug register file and the
// Ethernet frame builder. It generates per-frame requests with a fixed or
// incrementing length, enforces the inter-frame gap, counts frames and
// reports completion of count-mode runs.
// Optional feature macro: PKT_GEN_CTRL_WDOG_EN (XMIT watchdog, sticky err_o).
module pkt_gen_ctrl #(
    parameter int unsigned LEN_MIN  = 64,
    parameter int unsigned LEN_MAX  = 1518,
    parameter int unsigned IFG_MIN  = 12,
    parameter int unsigned WDOG_CYC = 4096
) (
    input  logic           clk_i,
    input  logic           rstb_i,
    input  logic           enable_i,
    input  logic           suspend_i,
    input  logic           send_mode_i,
    input  logic [31:0]    send_count_i,
    input  logic           pkt_len_mode_i,
    input  logic [15:0]    pkt_len_init_i,
    input  logic [15:0]    ifg_i,
    input  logic           total_clr_i,
    pkt_gen_ctrl_if.master frm,
    output logic           send_done_o,
    output logic [47:0]    total_cnt_o,
    output logic           busy_o,
    output logic           err_o
);

    localparam logic [15:0] LEN_MIN_C = 16'(LEN_MIN);
    localparam logic [15:0] LEN_MAX_C = 16'(LEN_MAX);
    localparam logic [15:0] IFG_MIN_C = 16'(IFG_MIN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XMIT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;

    // Run configuration, captured when a run starts
    logic        mode_q;
    logic [31:0] count_q;
    logic        len_mode_q;
    logic [15:0] init_q;
    logic [15:0] ifg_q;

    logic [15:0] len_q;
    logic [31:0] sent_q;
    logic [15:0] gap_q;
    logic [47:0] total_q;

    logic [15:0] len_init_clamp;
    logic [15:0] ifg_clamp;
    logic [31:0] sent_next;
    logic        start;
    logic        frame_done;
    logic        wdog_trip;
    logic        wdog_blk;

    assign sent_next = sent_q + 32'd1;

    // Clamp the configured length and gap into their legal ranges
    always_comb begin
        len_init_clamp = pkt_len_init_i;
        if (pkt_len_init_i < LEN_MIN_C) begin
            len_init_clamp = LEN_MIN_C;
        end else if (pkt_len_init_i > LEN_MAX_C) begin
            len_init_clamp = LEN_MAX_C;
        end
        ifg_clamp = (ifg_i < IFG_MIN_C) ? IFG_MIN_C : ifg_i;
    end

    // State register
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && !suspend_i && !wdog_blk) begin
                    start   = 1'b1;
                    state_d = (send_mode_i && (send_count_i == '0)) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (frm.frm_ack) begin
                    state_d = ST_XMIT;
                end
            end
            ST_XMIT: begin
                if (wdog_trip) begin
                    state_d = ST_IDLE;
                end else if (frm.frm_done) begin
                    frame_done = 1'b1;
                    if (mode_q && (sent_next == count_q)) begin
                        state_d = ST_DONE;
                    end else if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // Gap expiry is evaluated only at the last count; suspend
                // parks the counter there until it clears.
                if (gap_q <= 16'd1) begin
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (!suspend_i) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run shadow registers, frame length sequence, sent and gap counters
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            mode_q     <= 1'b0;
            count_q    <= '0;
            len_mode_q <= 1'b0;
            init_q     <= '0;
            ifg_q      <= '0;
            len_q      <= '0;
            sent_q     <= '0;
            gap_q      <= '0;
        end else begin
            if (start) begin
                mode_q     <= send_mode_i;
                count_q    <= send_count_i;
                len_mode_q <= pkt_len_mode_i;
                init_q     <= len_init_clamp;
                ifg_q      <= ifg_clamp;
                len_q      <= len_init_clamp;
                sent_q     <= '0;
            end
            if (frame_done) begin
                sent_q <= sent_next;
                gap_q  <= ifg_q;
                if (len_mode_q) begin
                    len_q <= (len_q == LEN_MAX_C) ? init_q : len_q + 16'd1;
                end
            end else if ((state_q == ST_GAP) && (gap_q > 16'd1)) begin
                gap_q <= gap_q - 16'd1;
            end
        end
    end

    // Total frame counter; a coincident clear takes priority over the count
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            total_q <= '0;
        end else if (total_clr_i) begin
            total_q <= '0;
        end else if (frame_done) begin
            total_q <= total_q + 48'd1;
        end
    end

`ifdef PKT_GEN_CTRL_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYC - 1);

    logic [31:0] wdog_cnt_q;
    logic        err_q;
    logic        wdog_blk_q;

    // A done pulse in the final watchdog cycle still completes the frame
    assign wdog_trip = (state_q == ST_XMIT) && !frm.frm_done && (wdog_cnt_q == WDOG_LAST);
    assign wdog_blk  = wdog_blk_q;
    assign err_o     = err_q;

    // XMIT cycle counter, sticky error and restart block until enable drops
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            wdog_cnt_q <= '0;
            err_q      <= 1'b0;
            wdog_blk_q <= 1'b0;
        end else begin
            wdog_cnt_q <= (state_q == ST_XMIT) ? wdog_cnt_q + 32'd1 : '0;
            if (wdog_trip) begin
                err_q      <= 1'b1;
                wdog_blk_q <= 1'b1;
            end else if (!enable_i) begin
                wdog_blk_q <= 1'b0;
            end
        end
    end
`else
    logic wdog_unused;

    assign wdog_trip   = 1'b0;
    assign wdog_blk    = 1'b0;
    assign err_o       = 1'b0;
    assign wdog_unused = (WDOG_CYC != 0);
`endif

    assign frm.frm_req = (state_q == ST_REQ);
    assign frm.frm_len = (state_q == ST_REQ) ? len_q : '0;
    assign send_done_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign total_cnt_o = total_q;

endmodule

// File: tb/tb_pkt_gen_ctrl.sv
// Directed self-checking bench for pkt_gen_ctrl. The bench plays the frame
// builder through the interface; build with +define+PKT_GEN_CTRL_WDOG_EN to
// exercise the watchdog.
module tb_pkt_gen_ctrl;

    logic        clk;
    logic        rstb;
    logic        enable;
    logic        suspend;
    logic        send_mode;
    logic [31:0] send_count;
    logic        len_mode;
    logic [15:0] len_init;
    logic [15:0] ifg;
    logic        total_clr;
    logic        send_done;
    logic [47:0] total_cnt;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int req_cyc = 0;
    int done_cyc = 0;

    pkt_gen_ctrl_if frm_bus ();

    pkt_gen_ctrl #(
        .LEN_MIN  (64),
        .LEN_MAX  (1518),
        .IFG_MIN  (12),
        .WDOG_CYC (16)
    ) dut (
        .clk_i          (clk),
        .rstb_i         (rstb),
        .enable_i       (enable),
        .suspend_i      (suspend),
        .send_mode_i    (send_mode),
        .send_count_i   (send_count),
        .pkt_len_mode_i (len_mode),
        .pkt_len_init_i (len_init),
        .ifg_i          (ifg),
        .total_clr_i    (total_clr),
        .frm            (frm_bus),
        .send_done_o    (send_done),
        .total_cnt_o    (total_cnt),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive and sample 1 ns after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstb       = 1'b0;
        enable     = 1'b0;
        suspend    = 1'b0;
        send_mode  = 1'b0;
        send_count = '0;
        len_mode   = 1'b0;
        len_init   = '0;
        ifg        = '0;
        total_clr  = 1'b0;
        frm_bus.frm_ack  = 1'b0;
        frm_bus.frm_done = 1'b0;
        repeat (2) tick();
        rstb = 1'b1;
        tick();
    endtask

    // Builder model: wait (bounded) for req, ack after ack_dly, done after done_dly
    task automatic run_frame(input int ack_dly, input int done_dly,
                             output logic [15:0] len, output bit ok);
        ok  = 1'b0;
        len = '0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (frm_bus.frm_req === 1'b1) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            req_cyc = cyc;
            len = frm_bus.frm_len;
            repeat (ack_dly) tick();
            frm_bus.frm_ack = 1'b1;
            tick();
            frm_bus.frm_ack = 1'b0;
            repeat (done_dly) tick();
            frm_bus.frm_done = 1'b1;
            done_cyc = cyc;
            tick();
            frm_bus.frm_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (frm_bus.frm_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b expected 0", frm_bus.frm_req); end
        n_cmp++; if (frm_bus.frm_len !== 16'd0) begin n_err++; $display("FAIL reset_len: got %0d expected 0", frm_bus.frm_len); end
        n_cmp++; if (send_done !== 1'b0) begin n_err++; $display("FAIL reset_send_done: got %0b expected 0", send_done); end
        n_cmp++; if (total_cnt !== 48'd0) begin n_err++; $display("FAIL reset_total: got %0d expected 0", total_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b expected 0", err); end
        // stray ack/done while idle must be ignored
        frm_bus.frm_ack = 1'b1; frm_bus.frm_done = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b0; frm_bus.frm_done = 1'b0;
        tick();
        n_cmp++; if (total_cnt !== 48'd0) begin n_err++; $display("FAIL idle_done_ignored: got %0d expected 0", total_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_ack_ignored: busy got %0b expected 0", busy); end
    endtask

    task automatic test_count_mode();
        logic [15:0] len;
        bit          ok;
        int          prev_done;
        apply_reset();
        send_mode = 1'b1; send_count = 32'd3; len_init = 16'd100; ifg = 16'd20;
        enable = 1'b1;
        prev_done = 0;
        for (int i = 0; i < 3; i++) begin
            run_frame(1, 50, len, ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL cnt_req_seen[%0d]: got %0b expected 1", i, ok); end
            n_cmp++; if (len !== 16'd100) begin n_err++; $display("FAIL cnt_len[%0d]: got %0d expected 100", i, len); end
            if (i > 0) begin
                n_cmp++; if (req_cyc - prev_done !== 21) begin n_err++; $display("FAIL cnt_spacing[%0d]: got %0d expected 21", i, req_cyc - prev_done); end
            end
            prev_done = done_cyc;
        end
        n_cmp++; if (send_done !== 1'b1) begin n_err++; $display("FAIL cnt_send_done: got %0b expected 1", send_done); end
        n_cmp++; if (total_cnt !== 48'd3) begin n_err++; $display("FAIL cnt_total: got %0d expected 3", total_cnt); end
        repeat (5) tick();
        n_cmp++; if (frm_bus.frm_req !== 1'b0) begin n_err++; $display("FAIL cnt_no_extra_req: got %0b expected 0", frm_bus.frm_req); end
        enable = 1'b0;
        tick();
        n_cmp++; if (send_done !== 1'b0) begin n_err++; $display("FAIL cnt_done_clear: got %0b expected 0", send_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cnt_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_len_incr();
        logic [15:0] exp_len [4];
        logic [15:0] len;
        bit          ok;
        exp_len[0] = 16'd1516; exp_len[1] = 16'd1517; exp_len[2] = 16'd1518; exp_len[3] = 16'd1516;
        apply_reset();
        send_mode = 1'b1; send_count = 32'd4; len_mode = 1'b1; len_init = 16'd1516; ifg = 16'd12;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_frame(0, 5, len, ok);
            n_cmp++; if (len !== exp_len[i]) begin n_err++; $display("FAIL incr_len[%0d]: got %0d expected %0d", i, len, exp_len[i]); end
        end
        n_cmp++; if (send_done !== 1'b1) begin n_err++; $display("FAIL incr_send_done: got %0b expected 1", send_done); end
        n_cmp++; if (total_cnt !== 48'd4) begin n_err++; $display("FAIL incr_total: got %0d expected 4", total_cnt); end
    endtask

    task automatic test_clamp();
        logic [15:0] len;
        bit          ok;
        int          prev_done;
        apply_reset();
        send_mode = 1'b1; send_count = 32'd2; len_init = 16'd10; ifg = 16'd3;
        enable = 1'b1;
        run_frame(0, 8, len, ok);
        n_cmp++; if (len !== 16'd64) begin n_err++; $display("FAIL clamp_len0: got %0d expected 64", len); end
        prev_done = done_cyc;
        run_frame(0, 8, len, ok);
        n_cmp++; if (len !== 16'd64) begin n_err++; $display("FAIL clamp_len1: got %0d expected 64", len); end
        n_cmp++; if (req_cyc - prev_done !== 13) begin n_err++; $display("FAIL clamp_spacing: got %0d expected 13", req_cyc - prev_done); end
        n_cmp++; if (send_done !== 1'b1) begin n_err++; $display("FAIL clamp_send_done: got %0b expected 1", send_done); end
    endtask

    task automatic test_suspend();
        logic [15:0] len;
        bit          ok;
        bit          saw_req;
        bit          held;
        int          prev_done;
        apply_reset();
        send_mode = 1'b0; len_init = 16'd200; ifg = 16'd12;
        enable = 1'b1;
        run_frame(0, 5, len, ok);
        prev_done = done_cyc;
        run_frame(0, 5, len, ok);
        n_cmp++; if (req_cyc - prev_done !== 13) begin n_err++; $display("FAIL susp_spacing: got %0d expected 13", req_cyc - prev_done); end
        suspend = 1'b1;
        saw_req = 1'b0;
        repeat (200) begin
            tick();
            if (frm_bus.frm_req !== 1'b0) saw_req = 1'b1;
        end
        n_cmp++; if (saw_req !== 1'b0) begin n_err++; $display("FAIL susp_no_req: got %0b expected 0", saw_req); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL susp_busy: got %0b expected 1", busy); end
        suspend = 1'b0;
        tick();
        n_cmp++; if (frm_bus.frm_req !== 1'b1) begin n_err++; $display("FAIL susp_resume_req: got %0b expected 1", frm_bus.frm_req); end
        enable = 1'b0;
        held = 1'b1;
        repeat (3) begin
            tick();
            if (frm_bus.frm_req !== 1'b1) held = 1'b0;
        end
        n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL req_held_no_enable: got %0b expected 1", held); end
        n_cmp++; if (frm_bus.frm_len !== 16'd200) begin n_err++; $display("FAIL req_held_len: got %0d expected 200", frm_bus.frm_len); end
        frm_bus.frm_ack = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b0;
        n_cmp++; if (frm_bus.frm_req !== 1'b0) begin n_err++; $display("FAIL xmit_req_low: got %0b expected 0", frm_bus.frm_req); end
        repeat (5) tick();
        frm_bus.frm_done = 1'b1;
        tick();
        frm_bus.frm_done = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %0b expected 0", busy); end
        n_cmp++; if (total_cnt !== 48'd3) begin n_err++; $display("FAIL stop_total: got %0d expected 3", total_cnt); end
    endtask

    task automatic test_total_clr();
        bit saw_req;
        apply_reset();
        send_mode = 1'b1; send_count = 32'd2; len_init = 16'd64; ifg = 16'd12;
        enable = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b0;
        force dut.total_q = 48'hFFFF_FFFF_FFFF;
        tick();
        release dut.total_q;
        tick();
        n_cmp++; if (total_cnt !== 48'hFFFF_FFFF_FFFF) begin n_err++; $display("FAIL clr_preload: got %0h expected ffffffffffff", total_cnt); end
        frm_bus.frm_done = 1'b1; total_clr = 1'b1;
        tick();
        frm_bus.frm_done = 1'b0; total_clr = 1'b0;
        n_cmp++; if (total_cnt !== 48'd0) begin n_err++; $display("FAIL clr_wins: got %0h expected 0", total_cnt); end
        for (int i = 0; i < 40 && frm_bus.frm_req !== 1'b1; i++) tick();
        frm_bus.frm_ack = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b0;
        force dut.total_q = 48'hFFFF_FFFF_FFFF;
        tick();
        release dut.total_q;
        tick();
        frm_bus.frm_done = 1'b1;
        tick();
        frm_bus.frm_done = 1'b0;
        n_cmp++; if (total_cnt !== 48'd0) begin n_err++; $display("FAIL total_wrap: got %0h expected 0", total_cnt); end
        n_cmp++; if (send_done !== 1'b1) begin n_err++; $display("FAIL clr_send_done: got %0b expected 1", send_done); end
        enable = 1'b0;
        tick();
        send_count = 32'd0;
        enable = 1'b1;
        tick();
        n_cmp++; if (send_done !== 1'b1) begin n_err++; $display("FAIL zero_count_done: got %0b expected 1", send_done); end
        saw_req = 1'b0;
        repeat (5) begin
            if (frm_bus.frm_req !== 1'b0) saw_req = 1'b1;
            tick();
        end
        n_cmp++; if (saw_req !== 1'b0) begin n_err++; $display("FAIL zero_count_no_req: got %0b expected 0", saw_req); end
    endtask

    task automatic test_async_reset();
        logic [15:0] len;
        bit          ok;
        apply_reset();
        send_mode = 1'b0; len_init = 16'd100; ifg = 16'd12;
        enable = 1'b1;
        run_frame(0, 4, len, ok);
        for (int i = 0; i < 40 && frm_bus.frm_req !== 1'b1; i++) tick();
        frm_bus.frm_ack = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b0;
        tick();
        n_cmp++; if (total_cnt !== 48'd1) begin n_err++; $display("FAIL arst_pre_total: got %0d expected 1", total_cnt); end
        #3;
        rstb = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %0b expected 0", busy); end
        n_cmp++; if (total_cnt !== 48'd0) begin n_err++; $display("FAIL arst_total: got %0d expected 0", total_cnt); end
        apply_reset();
    endtask

    task automatic test_watchdog();
        apply_reset();
        send_mode = 1'b0; len_init = 16'd100; ifg = 16'd12;
        enable = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b1;
        tick();
        frm_bus.frm_ack = 1'b0;
`ifdef PKT_GEN_CTRL_WDOG_EN
        repeat (15) tick();
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL wdog_early_err: got %0b expected 0", err); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wdog_early_busy: got %0b expected 1", busy); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL wdog_err: got %0b expected 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wdog_idle: got %0b expected 0", busy); end
        n_cmp++; if (total_cnt !== 48'd0) begin n_err++; $display("FAIL wdog_total: got %0d expected 0", total_cnt); end
        repeat (5) tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wdog_no_restart: got %0b expected 0", busy); end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wdog_restart: got %0b expected 1", busy); end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL wdog_sticky: got %0b expected 1", err); end
`else
        repeat (100) tick();
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL nowdog_err: got %0b expected 0", err); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL nowdog_busy: got %0b expected 1", busy); end
        frm_bus.frm_done = 1'b1;
        tick();
        frm_bus.frm_done = 1'b0;
        n_cmp++; if (total_cnt !== 48'd1) begin n_err++; $display("FAIL nowdog_total: got %0d expected 1", total_cnt); end
`endif
    endtask

    initial begin
        rstb = 1'b0;
        test_reset();
        test_count_mode();
        test_len_incr();
        test_clamp();
        test_suspend();
        test_total_clr();
        test_async_reset();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
